// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Fetch-stage controller in front of the instruction-register stage. Owns the
//   PC, addresses instruction memory, and splits the word stream into
//   instruction / immediate pairs. Handles boot (PC loaded from RESET_VEC),
//   two-word instructions (second word emitted as a bubble slot carrying the
//   immediate), jump redirects and interrupt entry (PC save + vector load).
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   stall_i        hold PC, state and registered outputs
//   jump_en_i      redirect request from execute
//   jump_addr_i    redirect target
//   int_req_i      interrupt request, latched into a pending flag
//   imem_data_i    instruction word read combinationally at imem_addr_o
//   imem_addr_o    instruction memory address
//   instr_o        instruction to IR stage (registered)
//   imm_o          immediate word (registered, held until the next immediate)
//   valid_o        instr_o is a live slot
//   bubble_o       slot is the immediate bubble
//   int_ack_o      one-cycle pulse: interrupt accepted
//   saved_pc_o     return PC captured at interrupt entry
//   saved_pc_vld_o one-cycle pulse alongside the saved_pc_o update
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int                PC_W      = 32,
    parameter logic [PC_W-1:0]   RESET_VEC = '0,
    parameter logic [PC_W-1:0]   INT_VEC   = PC_W'(1),
    parameter int                IMM_BIT   = 2,
    parameter logic [15:0]       BUBBLE_OP = 16'h07F8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            jump_en_i,
    input  logic [PC_W-1:0] jump_addr_i,
    input  logic            int_req_i,
    input  logic [15:0]     imem_data_i,
    output logic [PC_W-1:0] imem_addr_o,
    output logic [15:0]     instr_o,
    output logic [15:0]     imm_o,
    output logic            valid_o,
    output logic            bubble_o,
    output logic            int_ack_o,
    output logic [PC_W-1:0] saved_pc_o,
    output logic            saved_pc_vld_o
);

    typedef enum logic [2:0] {
        S_BOOT, S_FETCH, S_FETCH_IMM, S_INT_SAVE, S_INT_VEC
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] spc_q, spc_d;
    logic            int_pend_q, int_pend_d;
    logic [3:0]      hold_rd_q, hold_rd_d;
    logic [15:0]     instr_q, instr_d;
    logic [15:0]     imm_q, imm_d;
    logic            valid_q, valid_d;
    logic            bubble_q, bubble_d;
    logic            ack_q, ack_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VEC;
            spc_q      <= '0;
            int_pend_q <= 1'b0;
            hold_rd_q  <= '0;
            instr_q    <= '0;
            imm_q      <= '0;
            valid_q    <= 1'b0;
            bubble_q   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            spc_q      <= spc_d;
            int_pend_q <= int_pend_d;
            hold_rd_q  <= hold_rd_d;
            instr_q    <= instr_d;
            imm_q      <= imm_d;
            valid_q    <= valid_d;
            bubble_q   <= bubble_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        spc_d      = spc_q;
        hold_rd_d  = hold_rd_q;
        instr_d    = instr_q;
        imm_d      = imm_q;
        valid_d    = valid_q;
        bubble_d   = bubble_q;
        ack_d      = 1'b0;
        // Requests latch in every state, including while stalled.
        int_pend_d = int_pend_q | int_req_i;

        if (jump_en_i && (state_q == S_FETCH || state_q == S_FETCH_IMM)) begin
            // Redirect drops any half-fetched two-word instruction.
            pc_d     = jump_addr_i;
            valid_d  = 1'b0;
            bubble_d = 1'b0;
            state_d  = S_FETCH;
        end else if (!stall_i) begin
            case (state_q)
                S_BOOT: begin
                    pc_d     = PC_W'(imem_data_i);
                    valid_d  = 1'b0;
                    bubble_d = 1'b0;
                    state_d  = S_FETCH;
                end
                S_FETCH: begin
                    if (int_pend_q) begin
                        // Interrupts enter only here, so a two-word
                        // instruction is never split.
                        valid_d  = 1'b0;
                        bubble_d = 1'b0;
                        state_d  = S_INT_SAVE;
                    end else begin
                        instr_d  = imem_data_i;
                        valid_d  = 1'b1;
                        bubble_d = 1'b0;
                        pc_d     = pc_q + PC_W'(1);
                        if (imem_data_i[IMM_BIT]) begin
                            hold_rd_d = imem_data_i[6:3];
                            state_d   = S_FETCH_IMM;
                        end
                    end
                end
                S_FETCH_IMM: begin
                    imm_d        = imem_data_i;
                    instr_d      = BUBBLE_OP;
                    instr_d[6:3] = hold_rd_q;
                    valid_d      = 1'b1;
                    bubble_d     = 1'b1;
                    pc_d         = pc_q + PC_W'(1);
                    state_d      = S_FETCH;
                end
                S_INT_SAVE: begin
                    spc_d      = pc_q;
                    ack_d      = 1'b1;
                    // A request arriving now is serviced after this one.
                    int_pend_d = int_req_i;
                    valid_d    = 1'b0;
                    bubble_d   = 1'b0;
                    state_d    = S_INT_VEC;
                end
                S_INT_VEC: begin
                    pc_d     = PC_W'(imem_data_i);
                    valid_d  = 1'b0;
                    bubble_d = 1'b0;
                    state_d  = S_FETCH;
                end
                default: state_d = S_BOOT;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            S_BOOT:    imem_addr_o = RESET_VEC;
            S_INT_VEC: imem_addr_o = INT_VEC;
            default:   imem_addr_o = pc_q;
        endcase
    end

    assign instr_o        = instr_q;
    assign imm_o          = imm_q;
    assign valid_o        = valid_q;
    assign bubble_o       = bubble_q;
    assign int_ack_o      = ack_q;
    assign saved_pc_o     = spc_q;
    assign saved_pc_vld_o = ack_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, jump_en, int_req;
    logic [31:0] jump_addr;
    logic [15:0] imem_data;
    logic [31:0] imem_addr;
    logic [15:0] instr, imm;
    logic        valid, bubble, int_ack, spc_vld;
    logic [31:0] saved_pc;

    logic [15:0] mem [0:255];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[7:0]];

    fetch_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .jump_en_i(jump_en),
        .jump_addr_i(jump_addr), .int_req_i(int_req), .imem_data_i(imem_data),
        .imem_addr_o(imem_addr), .instr_o(instr), .imm_o(imm), .valid_o(valid),
        .bubble_o(bubble), .int_ack_o(int_ack), .saved_pc_o(saved_pc),
        .saved_pc_vld_o(spc_vld)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0010;  // boot PC
        mem[8'h01] = 16'h0030;  // interrupt handler
        mem[8'h10] = 16'h002C;  // two-word, rd field 4'b0101
        mem[8'h11] = 16'hBEEF;
        mem[8'h30] = 16'h0044;  // two-word, rd field 4'b1000
        mem[8'h31] = 16'hCAFE;
        mem[8'h32] = 16'h0024;  // two-word, rd field 4'b0100
        mem[8'h40] = 16'h0001;
        mem[8'hFF] = 16'h0008;  // single-word at 0xFFFFFFFF

        rst_n = 1'b0; stall = 0; jump_en = 0; int_req = 0; jump_addr = '0;
        #12;
        chk("rst_valid", valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_addr", imem_addr, 32'h0);
        step();
        rst_n = 1'b1;

        // boot
        step();
        chk("boot_addr", imem_addr, 32'h10);
        chk("boot_valid", valid, 0);
        int_req = 1'b1;                // arrives with the first word
        step();
        int_req = 1'b0;
        chk("w1_instr", instr, 16'h002C);
        chk("w1_valid", valid, 1);
        chk("w1_bubble", bubble, 0);
        step();
        chk("w2_instr", instr, 16'h07A8);
        chk("w2_imm", imm, 16'hBEEF);
        chk("w2_bubble", bubble, 1);
        chk("w2_pc", imem_addr, 32'h12);

        // interrupt taken after the pair completes
        step();
        chk("intf_valid", valid, 0);
        chk("intf_ack", int_ack, 0);
        step();
        chk("ints_ack", int_ack, 1);
        chk("ints_vld", spc_vld, 1);
        chk("ints_spc", saved_pc, 32'h12);
        chk("ints_addr", imem_addr, 32'h1);
        step();
        chk("intv_ack", int_ack, 0);
        chk("intv_vld", spc_vld, 0);
        chk("intv_pc", imem_addr, 32'h30);

        // stall inside a two-word instruction
        step();
        chk("h1_instr", instr, 16'h0044);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl_instr", instr, 16'h0044);
            chk("stl_bubble", bubble, 0);
            chk("stl_addr", imem_addr, 32'h31);
        end
        stall = 1'b0;
        step();
        chk("stl_rel_instr", instr, 16'h07C0);
        chk("stl_rel_imm", imm, 16'hCAFE);
        chk("stl_rel_bubble", bubble, 1);
        step();
        chk("j0_instr", instr, 16'h0024);
        chk("j0_bubble", bubble, 0);

        // jump in FETCH_IMM
        jump_en = 1'b1; jump_addr = 32'h40;
        step();
        jump_en = 1'b0;
        chk("jmp_valid", valid, 0);
        chk("jmp_bubble", bubble, 0);
        chk("jmp_imm", imm, 16'hCAFE);
        chk("jmp_addr", imem_addr, 32'h40);
        step();
        chk("jmp_instr", instr, 16'h0001);
        chk("jmp_valid2", valid, 1);

        // pc wrap
        jump_en = 1'b1; jump_addr = 32'hFFFF_FFFF;
        step();
        jump_en = 1'b0;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFF);
        step();
        chk("wrap_instr", instr, 16'h0008);
        chk("wrap_addr1", imem_addr, 32'h0);

        // interrupt, then reset while in INT_VEC with another request pending
        int_req = 1'b1;
        step();
        int_req = 1'b0;
        chk("i2_instr", instr, 16'h0010);
        step();
        chk("i2_valid", valid, 0);
        int_req = 1'b1;                // during INT_SAVE: re-pends
        step();
        int_req = 1'b0;
        chk("i2_spc", saved_pc, 32'h1);
        chk("i2_ack", int_ack, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_instr", instr, 0);
        chk("arst_imm", imm, 0);
        chk("arst_spc", saved_pc, 0);
        chk("arst_ack", int_ack, 0);
        chk("arst_addr", imem_addr, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("reboot_addr", imem_addr, 32'h10);
        step();
        chk("reboot_instr", instr, 16'h002C);
        chk("reboot_valid", valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
